mux_scan_seq: RTL
=================

// Module: mux_scan_seq
// PURPOSE
//  Upstream sequencer for the 8-to-1 mux (mux_8to1). Drives select lines s2,s1,s0
//    through channels 0..7 and waits a programmable settle time on each channel.
//  Samples the mux output y once per channel and assembles an 8-bit word.
//  Delivers the word on a valid/ready output handshake.
//  Turns 8 static single-bit sources into one parallel word on demand.
// PARAMETERS
//  SETTLE_CYC  1  extra cycles held on each channel before sampling y_in (0..255)
// PORTS
//  clk         in   1  single clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  start       in   1  scan request; accepted only in IDLE or on a DONE handshake
//  y_in        in   1  from mux_8to1 output y
//  s2,s1,s0    out  1  registered select to mux_8to1 (s2 = MSB)
//  busy        out  1  high whenever state != IDLE
//  data_out    out  8  assembled word, bit[n] = y_in sampled while {s2,s1,s0}==n
//  data_valid  out  1  word available
//  data_ready  in   1  consumer accepts word
//  ch_mask     in   8  only with SCAN_MASK_EN; 1 = scan channel
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; s=3'b000; busy=0; data_out=8'h00; data_valid=0.
//    Settle counter and shadow word are cleared.
//    A reset mid-scan discards the partial word; no data_valid is produced.
//  FSM states: IDLE, SETTLE, DONE.
//  IDLE, start=1 at clock edge:
//    ch=0; {s2,s1,s0}=0; cnt=SETTLE_CYC; shadow=0; go to SETTLE.
//  SETTLE, cnt!=0: cnt decrements; select held.
//  SETTLE, cnt==0: shadow[ch]<=y_in.
//    If ch==7: data_out<=full word (incl. this bit); data_valid<=1; go to DONE.
//    Else: ch<=ch+1; select<=ch+1; cnt<=SETTLE_CYC.
//  Timing: each channel occupies SETTLE_CYC+1 cycles.
//    data_valid rises 8*(SETTLE_CYC+1) edges after the start edge.
//    SETTLE_CYC=0 gives one channel per cycle; y_in is sampled combinationally
//    in the same cycle its select is presented.
//  DONE:
//    data_valid=1; data_out and select (=7) held stable until data_ready=1 at an edge.
//    data_ready=1 & start=0: data_valid<=0; go to IDLE.
//    data_ready=1 & start=1: data_valid<=0; new scan starts exactly as from IDLE
//      (back-to-back, no idle cycle).
//    data_ready=0: start is ignored.
//  start in SETTLE is ignored; there is no queueing.
//  Select after a scan stays at the last channel until the next scan begins.
//  data_out changes only on entry to DONE; it is never partially updated.
//  y_in is assumed stable per channel. No synchronisation is done here.
// CONFIGURATION
//  SCAN_MASK_EN defined:
//    ch_mask port present; ch_mask is registered at start acceptance.
//    The scan visits only enabled channels, in ascending order.
//    Disabled channels cost 0 cycles and read as 0 in data_out.
//    First channel = lowest set bit. After the highest set bit the FSM goes to DONE.
//    Latency = popcount(mask)*(SETTLE_CYC+1).
//    ch_mask==8'h00: DONE on the edge after start; data_out=8'h00; select unchanged.
//  SCAN_MASK_EN undefined:
//    No ch_mask port; all 8 channels are scanned always (equivalent to mask 8'hFF).
// TESTING (bench instantiates mux_scan_seq driving a mux_8to1 with sources i0..i7)
//  1. Reset: rst_n=0 mid-cycle -> all outputs 0 immediately, without waiting for clk.
//  2. SETTLE_CYC=1, i7..i0=8'hA5, start pulse:
//       select 0..7, each held 2 cycles; data_valid rises at edge 16; data_out=8'hA5.
//  3. Backpressure: data_ready=0 for 20 cycles in DONE, start pulsed ->
//       data_valid=1, data_out=8'hA5 and select=7 all stable; no new scan.
//  4. Back-to-back: data_ready=1 & start=1 in DONE, i7..i0=8'h3C ->
//       next edge select=0, busy stays 1; second word 8'h3C 16 cycles later.
//  5. Reset at channel 4, then start with i7..i0=8'hFF ->
//       no valid from the aborted scan; new word=8'hFF after 16 cycles.
//  6. SCAN_MASK_EN, SETTLE_CYC=0, ch_mask=8'h81, sources 8'hFF ->
//       only select 0 and 7 visited; data_out=8'h81 with valid at edge 2.
//     ch_mask=8'h00 -> valid at edge 1, data_out=8'h00.

Source files
------------

// File: rtl/mux_scan_seq_if.sv
// Scan sequencer bus: request, select to the 8:1 mux, sampled mux output,
// and the valid/ready word handshake. When SCAN_MASK_EN is defined the
// bus also carries the per-channel scan enable mask ch_mask.
`timescale 1ns/1ps
interface mux_scan_seq_if;
  logic       start;
  logic       y_in;
  logic       s2;
  logic       s1;
  logic       s0;
  logic       busy;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
`ifdef SCAN_MASK_EN
  logic [7:0] ch_mask;
`endif

  // Sequencer side
  modport slave (
`ifdef SCAN_MASK_EN
    input  ch_mask,
`endif
    input  start,
    input  y_in,
    input  data_ready,
    output s2,
    output s1,
    output s0,
    output busy,
    output data_out,
    output data_valid
  );

  // Requester / consumer side
  modport master (
`ifdef SCAN_MASK_EN
    output ch_mask,
`endif
    output start,
    output y_in,
    output data_ready,
    input  s2,
    input  s1,
    input  s0,
    input  busy,
    input  data_out,
    input  data_valid
  );
endinterface

// File: rtl/mux_scan_seq.sv
// mux_scan_seq: walks the select lines of an 8:1 mux over its channels,
// holds each channel SETTLE_CYC extra cycles, samples y_in once per channel
// and offers the assembled 8-bit word on a valid/ready handshake.
// Optional feature macro: SCAN_MASK_EN (adds ch_mask; only enabled channels
// are visited, disabled channels read as 0 and cost no cycles).
`timescale 1ns/1ps
module mux_scan_seq #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_scan_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC);

  state_t     state_reg;
  logic [2:0] sel_reg;        // current channel, also the select driven to the mux
  logic [7:0] cnt_reg;        // remaining settle cycles on the current channel
  logic [7:0] shadow_reg;     // word under assembly, never exposed directly
  logic [7:0] data_out_reg;
  logic       data_valid_reg;
  logic       busy_reg;

  logic [7:0] mask_cur;       // channels enabled for the scan in progress
  logic [7:0] launch_mask;    // channels to enable if a scan is accepted now
  logic [7:0] above_mask;     // enabled channels strictly above sel_reg
  logic [7:0] word_next;      // shadow word with the current channel's sample merged
  logic [2:0] launch_first;
  logic [2:0] next_ch;
  logic       launch_empty;
  logic       mask_empty;
  logic       last_ch;
  logic       start_accept;

  // Index of the lowest set bit; 0 when none is set (callers check emptiness).
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

`ifdef SCAN_MASK_EN
  logic [7:0] mask_reg;       // ch_mask captured when the scan was accepted
  assign mask_cur    = mask_reg;
  assign launch_mask = bus.ch_mask;
`else
  assign mask_cur    = 8'hFF;
  assign launch_mask = 8'hFF;
`endif

  // Per-channel helpers: which enabled channels remain, and the merged word.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_chan
      assign above_mask[gi] = mask_cur[gi] & (3'(gi) > sel_reg);
      assign word_next[gi]  = (sel_reg == 3'(gi)) ? bus.y_in : shadow_reg[gi];
    end
  endgenerate

  // Scan sequencing decisions derived from the current state and masks.
  always_comb begin
    launch_first = lowest_set(launch_mask);
    launch_empty = (launch_mask == 8'h00);
    mask_empty   = (mask_cur == 8'h00);
    next_ch      = lowest_set(above_mask);
    last_ch      = (above_mask == 8'h00);
    start_accept = bus.start &&
                   ((state_reg == IDLE) || ((state_reg == DONE) && bus.data_ready));
  end

  // Scan FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      sel_reg        <= 3'd0;
      cnt_reg        <= 8'd0;
      shadow_reg     <= 8'h00;
      data_out_reg   <= 8'h00;
      data_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef SCAN_MASK_EN
      mask_reg       <= 8'h00;
`endif
    end else if (start_accept) begin
      // New scan from IDLE or straight out of a completed DONE handshake.
      // An empty mask keeps the select where it was and finishes next edge.
      state_reg      <= SETTLE;
      cnt_reg        <= launch_empty ? 8'd0 : SETTLE_LOAD;
      shadow_reg     <= 8'h00;
      data_valid_reg <= 1'b0;
      busy_reg       <= 1'b1;
      if (!launch_empty) begin
        sel_reg <= launch_first;
      end
`ifdef SCAN_MASK_EN
      mask_reg       <= bus.ch_mask;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          busy_reg <= 1'b0;
        end
        SETTLE: begin
          if (cnt_reg != 8'd0) begin
            cnt_reg <= cnt_reg - 8'd1;
          end else if (mask_empty) begin
            data_out_reg   <= shadow_reg;
            data_valid_reg <= 1'b1;
            state_reg      <= DONE;
          end else begin
            shadow_reg <= word_next;
            if (last_ch) begin
              data_out_reg   <= word_next;
              data_valid_reg <= 1'b1;
              state_reg      <= DONE;
            end else begin
              sel_reg <= next_ch;
              cnt_reg <= SETTLE_LOAD;
            end
          end
        end
        DONE: begin
          // Word and select stay frozen until the consumer takes the word.
          if (bus.data_ready) begin
            data_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: begin
          state_reg      <= IDLE;
          data_valid_reg <= 1'b0;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s2         = sel_reg[2];
  assign bus.s1         = sel_reg[1];
  assign bus.s0         = sel_reg[0];
  assign bus.busy       = busy_reg;
  assign bus.data_out   = data_out_reg;
  assign bus.data_valid = data_valid_reg;

endmodule
